// File: rtl/multi_freq_serial_out.sv
// Multi-channel serial pattern generator. A UART byte parser feeds per-channel two-speed bit engines.
// Optional feature: define PARSER_TIMEOUT_EN to abort stalled packets after TIMEOUT_CLK idle clocks.
module multi_freq_serial_out #(
  parameter int unsigned DATA_BIT        = 32,
  parameter int unsigned OUTPUT_NUM      = 16,
  parameter int unsigned PERIOD_W        = 8,
  parameter int unsigned LOW_PERIOD_CLK  = 20,
  parameter int unsigned HIGH_PERIOD_CLK = 5,
  parameter int unsigned TIMEOUT_CLK     = 50000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            data_i,
  input  logic                  rx_done_tick_i,
  output logic [OUTPUT_NUM-1:0] serial_out_o,
  output logic [OUTPUT_NUM-1:0] busy_o,
  output logic [OUTPUT_NUM-1:0] bit_tick_o,
  output logic [OUTPUT_NUM-1:0] done_tick_o,
  output logic                  cmd_err_o
);

  localparam int unsigned K     = DATA_BIT / 8;
  localparam int unsigned IDX_W = $clog2(DATA_BIT);

  localparam logic [7:0] CmdFreq = 8'h0A;
  localparam logic [7:0] CmdData = 8'h0B;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StFreqCh   = 3'd1;
  localparam logic [2:0] StFreqPat  = 3'd2;
  localparam logic [2:0] StFreqSlow = 3'd3;
  localparam logic [2:0] StFreqFast = 3'd4;
  localparam logic [2:0] StDataPat  = 3'd5;
  localparam logic [2:0] StDataCtrl = 3'd6;

  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? PERIOD_W'(1) : p;
  endfunction

  // ---------------------------------------------------------------------------
  // Packet parser
  // ---------------------------------------------------------------------------
  logic [2:0]          state_q, state_d;
  logic [2:0]          bcnt_q, bcnt_d;
  logic [7:0]          ch_q, ch_d;
  logic [DATA_BIT-1:0] acc_q, acc_d;
  logic [PERIOD_W-1:0] pslow_q, pslow_d;
  logic                err_q, err_d;

  logic                freq_wr;
  logic                data_wr;
  logic [7:0]          wr_ch;
  logic                timeout;

`ifdef PARSER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CLK + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (state_q != StIdle && !rx_done_tick_i) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CLK - 1)) begin
        timeout = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Commits are combinational in the cycle of the final byte so shadows update one edge later.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    pslow_d = pslow_q;
    err_d   = 1'b0;
    freq_wr = 1'b0;
    data_wr = 1'b0;
    wr_ch   = ch_q;
    if (rx_done_tick_i) begin
      case (state_q)
        StIdle: begin
          if (data_i == CmdFreq) begin
            state_d = StFreqCh;
          end else if (data_i == CmdData) begin
            state_d = StDataPat;
            bcnt_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        StFreqCh: begin
          ch_d    = data_i;
          bcnt_d  = '0;
          state_d = StFreqPat;
        end
        StFreqPat, StDataPat: begin
          for (int k = 0; k < K; k++) begin
            if (bcnt_q == 3'(k)) acc_d[k*8 +: 8] = data_i;
          end
          if (bcnt_q == 3'(K - 1)) begin
            state_d = (state_q == StFreqPat) ? StFreqSlow : StDataCtrl;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
        StFreqSlow: begin
          pslow_d = PERIOD_W'(data_i);
          state_d = StFreqFast;
        end
        StFreqFast: begin
          state_d = StIdle;
          if (ch_q < 8'(OUTPUT_NUM)) freq_wr = 1'b1;
          else                       err_d   = 1'b1;
        end
        StDataCtrl: begin
          state_d = StIdle;
          wr_ch   = {4'h0, data_i[7:4]};
          if (wr_ch < 8'(OUTPUT_NUM)) data_wr = 1'b1;
          else                        err_d   = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
    if (timeout) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      bcnt_q  <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      pslow_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      pslow_q <= pslow_d;
      err_q   <= err_d;
    end
  end

  assign cmd_err_o = err_q;

  // ---------------------------------------------------------------------------
  // Per-channel shadow registers and bit engines
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < OUTPUT_NUM; c++) begin : g_ch
    logic                sel;
    logic [DATA_BIT-1:0] sh_pat_q, sh_fpat_q;
    logic [PERIOD_W-1:0] sh_slow_q, sh_fast_q;
    logic                sh_idle_q, sh_mode_q;
    logic                start_req_q, stop_req_q;

    logic [DATA_BIT-1:0] w_pat_q, w_pat_d, w_fpat_q, w_fpat_d;
    logic [PERIOD_W-1:0] w_slow_q, w_slow_d, w_fast_q, w_fast_d;
    logic                w_mode_q, w_mode_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                bit_tick_q, bit_tick_d;
    logic                done_q, done_d;
    logic [PERIOD_W-1:0] cur_p;
    logic                load;

    assign sel = (wr_ch == 8'(c));

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sh_pat_q    <= '0;
        sh_fpat_q   <= '0;
        sh_slow_q   <= PERIOD_W'(LOW_PERIOD_CLK);
        sh_fast_q   <= PERIOD_W'(HIGH_PERIOD_CLK);
        sh_idle_q   <= 1'b0;
        sh_mode_q   <= 1'b0;
        start_req_q <= 1'b0;
        stop_req_q  <= 1'b0;
      end else begin
        // Stop dominates start.
        start_req_q <= data_wr && sel && data_i[0] && !data_i[2];
        stop_req_q  <= data_wr && sel && data_i[2];
        if (freq_wr && sel) begin
          sh_fpat_q <= acc_q;
          sh_slow_q <= pslow_q;
          sh_fast_q <= PERIOD_W'(data_i);
        end
        if (data_wr && sel) begin
          sh_pat_q  <= acc_q;
          sh_idle_q <= data_i[3];
          sh_mode_q <= data_i[1];
        end
      end
    end

    assign cur_p = w_fpat_q[idx_q] ? w_fast_q : w_slow_q;

    always_comb begin
      w_pat_d    = w_pat_q;
      w_fpat_d   = w_fpat_q;
      w_slow_d   = w_slow_q;
      w_fast_d   = w_fast_q;
      w_mode_d   = w_mode_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      bit_tick_d = 1'b0;
      done_d     = 1'b0;
      load       = 1'b0;
      if (stop_req_q) begin
        busy_d = 1'b0;
      end else if (start_req_q) begin
        load = 1'b1;
      end else if (busy_q) begin
        if (cnt_q == cur_p - PERIOD_W'(1)) begin
          cnt_d = '0;
          if (idx_q == IDX_W'(DATA_BIT - 1)) begin
            done_d = 1'b1;
            if (w_mode_q) begin
              load       = 1'b1;
              bit_tick_d = 1'b1;
            end else begin
              busy_d = 1'b0;
            end
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            bit_tick_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      if (load) begin
        w_pat_d  = sh_pat_q;
        w_fpat_d = sh_fpat_q;
        w_slow_d = eff_period(sh_slow_q);
        w_fast_d = eff_period(sh_fast_q);
        w_mode_d = sh_mode_q;
        idx_d    = '0;
        cnt_d    = '0;
        busy_d   = 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        w_pat_q    <= '0;
        w_fpat_q   <= '0;
        w_slow_q   <= PERIOD_W'(1);
        w_fast_q   <= PERIOD_W'(1);
        w_mode_q   <= 1'b0;
        idx_q      <= '0;
        cnt_q      <= '0;
        busy_q     <= 1'b0;
        bit_tick_q <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        w_pat_q    <= w_pat_d;
        w_fpat_q   <= w_fpat_d;
        w_slow_q   <= w_slow_d;
        w_fast_q   <= w_fast_d;
        w_mode_q   <= w_mode_d;
        idx_q      <= idx_d;
        cnt_q      <= cnt_d;
        busy_q     <= busy_d;
        bit_tick_q <= bit_tick_d;
        done_q     <= done_d;
      end
    end

    assign serial_out_o[c] = busy_q ? w_pat_q[idx_q] : sh_idle_q;
    assign busy_o[c]       = busy_q;
    assign bit_tick_o[c]   = bit_tick_q;
    assign done_tick_o[c]  = done_q;
  end

endmodule

// File: tb/tb_multi_freq_serial_out.sv
// Directed self-checking bench for multi_freq_serial_out (16-channel DUT plus an 8-channel copy).
module tb_multi_freq_serial_out;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        tick;

  logic [15:0] serial, busy, btick, done;
  logic        err;
  logic [7:0]  serial8, busy8, btick8, done8;
  logic        err8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_freq_serial_out #(.OUTPUT_NUM(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .data_i         (data),
    .rx_done_tick_i (tick),
    .serial_out_o   (serial),
    .busy_o         (busy),
    .bit_tick_o     (btick),
    .done_tick_o    (done),
    .cmd_err_o      (err)
  );

  multi_freq_serial_out #(.OUTPUT_NUM(8)) dut8 (
    .clk_i          (clk),
    .rst_i          (rst),
    .data_i         (data),
    .rx_done_tick_i (tick),
    .serial_out_o   (serial8),
    .busy_o         (busy8),
    .bit_tick_o     (btick8),
    .done_tick_o    (done8),
    .cmd_err_o      (err8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the edge that sampled the byte, i.e. in cycle T+1.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 data = b;
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  endtask

  task automatic send_freq(input logic [7:0] ch, input logic [31:0] pat,
                           input logic [7:0] slow, input logic [7:0] fast);
    send_byte(8'h0A);
    send_byte(ch);
    for (int k = 0; k < 4; k++) send_byte(pat[8*k +: 8]);
    send_byte(slow);
    send_byte(fast);
  endtask

  task automatic send_data(input logic [31:0] pat, input logic [7:0] ctrl);
    send_byte(8'h0B);
    for (int k = 0; k < 4; k++) send_byte(pat[8*k +: 8]);
    send_byte(ctrl);
  endtask

  initial begin
    int nd;
    rst  = 1'b1;
    data = 8'h00;
    tick = 1'b0;
    #12;
    chk("rst_serial", 64'(serial), 64'h0);
    chk("rst_busy",   64'(busy),   64'h0);
    chk("rst_btick",  64'(btick),  64'h0);
    chk("rst_done",   64'(done),   64'h0);
    chk("rst_err",    64'(err),    64'h0);
    rst = 1'b0;
    step(2);

    // ch0 one-shot, all slow (20 clk per bit)
    send_freq(8'h00, 32'h0000_0000, 8'd20, 8'd5);
    send_data(32'h5555_5555, 8'h01);
    chk("c0_t1_err",  64'(err),     64'h0);
    chk("c0_t1_busy", 64'(busy[0]), 64'h0);
    step(1);
    chk("c0_t2_busy",   64'(busy[0]),   64'h1);
    chk("c0_t2_serial", 64'(serial[0]), 64'h1);
    chk("c0_t2_btick",  64'(btick[0]),  64'h0);
    step(19);
    chk("c0_t21_serial", 64'(serial[0]), 64'h1);
    step(1);
    chk("c0_t22_serial", 64'(serial[0]), 64'h0);
    chk("c0_t22_btick",  64'(btick[0]),  64'h1);
    step(1);
    chk("c0_t23_btick", 64'(btick[0]), 64'h0);
    step(618);
    chk("c0_t641_busy", 64'(busy[0]), 64'h1);
    chk("c0_t641_done", 64'(done[0]), 64'h0);
    step(1);
    chk("c0_t642_done",   64'(done[0]),   64'h1);
    chk("c0_t642_busy",   64'(busy[0]),   64'h0);
    chk("c0_t642_serial", 64'(serial[0]), 64'h0);
    step(1);
    chk("c0_t643_done", 64'(done[0]), 64'h0);

    // ch3 repeat: bits 0-15 slow, 16-31 fast, 400 clk per pass
    send_freq(8'h03, 32'hFFFF_0000, 8'd20, 8'd5);
    send_data(32'h5555_5555, 8'h33);
    step(1);
    chk("c3_t2_busy",   64'(busy[3]),   64'h1);
    chk("c3_t2_serial", 64'(serial[3]), 64'h1);
    step(320);
    chk("c3_t322_serial", 64'(serial[3]), 64'h1);
    chk("c3_t322_btick",  64'(btick[3]),  64'h1);
    step(5);
    chk("c3_t327_serial", 64'(serial[3]), 64'h0);
    chk("c3_t327_btick",  64'(btick[3]),  64'h1);
    step(74);
    chk("c3_t401_done",   64'(done[3]),   64'h0);
    chk("c3_t401_serial", 64'(serial[3]), 64'h0);
    step(1);
    chk("c3_t402_done",   64'(done[3]),   64'h1);
    chk("c3_t402_busy",   64'(busy[3]),   64'h1);
    chk("c3_t402_serial", 64'(serial[3]), 64'h1);
    chk("c3_t402_btick",  64'(btick[3]),  64'h1);
    step(399);
    chk("c3_t801_done", 64'(done[3]), 64'h0);
    step(1);
    chk("c3_t802_done", 64'(done[3]), 64'h1);

    // stop ch3 with idle=1
    send_data(32'h0000_0000, 8'h3C);
    chk("stop_t1_busy", 64'(busy[3]), 64'h1);
    step(1);
    chk("stop_t2_serial", 64'(serial[3]), 64'h1);
    chk("stop_t2_busy",   64'(busy[3]),   64'h0);
    chk("stop_t2_done",   64'(done[3]),   64'h0);
    nd = 0;
    for (int i = 0; i < 450; i++) begin
      step(1);
      if (done[3]) nd++;
    end
    chk("stop_no_done",   64'(nd),        64'h0);
    chk("stop_idle_hold", 64'(serial[3]), 64'h1);

    // unknown command, bad FREQ channel, DATA chan 15 on both DUTs
    send_byte(8'h0C);
    chk("bad_cmd_err",  64'(err),  64'h1);
    chk("bad_cmd_err8", 64'(err8), 64'h1);
    step(1);
    chk("bad_cmd_err_clr", 64'(err), 64'h0);
    send_freq(8'h20, 32'h1234_5678, 8'd3, 8'd3);
    chk("bad_freq_ch_err", 64'(err), 64'h1);
    send_data(32'h0000_0003, 8'hF1);
    chk("c15_err16", 64'(err),  64'h0);
    chk("c15_err8",  64'(err8), 64'h1);
    step(1);
    chk("c15_busy",   64'(busy[15]),   64'h1);
    chk("c15_serial", 64'(serial[15]), 64'h1);
    chk("c15_busy8",  64'(busy8),      64'h0);

    // ch5 and ch6 back-to-back one-shots at default periods
    send_data(32'h5555_5555, 8'h51);
    send_data(32'h5555_5555, 8'h61);
    step(628);
    chk("c5_pre_done", 64'(done[5]), 64'h0);
    step(1);
    chk("c5_done",      64'(done[5]), 64'h1);
    chk("c6_not_done",  64'(done[6]), 64'h0);
    chk("c6_still_busy", 64'(busy[6]), 64'h1);
    step(12);
    chk("c6_done",       64'(done[6]), 64'h1);
    chk("c5_done_clear", 64'(done[5]), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_freq_serial_out.md
Name: multi_freq_serial_out

Overview:
Parametrised multi-channel serial pattern generator with a per-channel two-speed bit clock. It consumes UART-received command bytes, parses FREQ and DATA packets, and drives OUTPUT_NUM independent serial outputs. Each channel has its own slow/fast periods, its own frequency-select pattern, idle level and mode. It sits directly behind the UART RX (data_i/rx_done_tick_i) in the pattern-output FPGA design.

Parameters:
DATA_BIT, 32, pattern width; multiple of 8, range 8..64
OUTPUT_NUM, 16, channel count; range 1..16
PERIOD_W, 8, width of period registers and bit counters
LOW_PERIOD_CLK, 20, reset value of every channel's slow period
HIGH_PERIOD_CLK, 5, reset value of every channel's fast period
TIMEOUT_CLK, 50000, inter-byte timeout in clocks; used only with the optional feature

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
data_i  in  8  received UART byte
rx_done_tick_i  in  1  one-cycle strobe; data_i valid
serial_out_o  out  OUTPUT_NUM  serial outputs
busy_o  out  OUTPUT_NUM  channel running
bit_tick_o  out  OUTPUT_NUM  one-cycle pulse at each bit boundary per channel
done_tick_o  out  OUTPUT_NUM  one-cycle pulse at each pattern completion per channel
cmd_err_o  out  1  one-cycle pulse on a rejected or aborted packet

Behaviour:
- Reset (async, rst_i=1): all outputs 0. Parser IDLE. All shadow patterns 0, freq patterns 0, idle levels 0, slow=LOW_PERIOD_CLK, fast=HIGH_PERIOD_CLK, engines IDLE.
- Byte order: multi-byte fields are sent LSB byte first; K = DATA_BIT/8.
- FREQ packet: 0x0A, channel byte, K freq-pattern bytes, slow period, fast period.
- DATA packet: 0x0B, K pattern bytes, control byte {chan[3:0], idle, stop, mode, start}. mode: 0 = one-shot, 1 = repeat.
- Parser states: IDLE, FREQ_CH, FREQ_PAT, FREQ_SLOW, FREQ_FAST, DATA_PAT, DATA_CTRL. It advances only on rx_done_tick_i.
- Unknown command byte in IDLE: cmd_err_o pulses the next cycle; parser stays IDLE.
- Commit: on the last byte at cycle T, shadow registers for the channel are written at T+1.
- Channel ≥ OUTPUT_NUM: the packet is discarded and cmd_err_o pulses at T+1.
- FREQ updates shadow registers only. A running channel picks them up at its next pattern start or repeat wrap.
- Period value 0 is treated as 1.
- DATA with start=1: the engine loads pattern, freq pattern and periods into working registers and enters RUN. bit0 appears on serial_out_o at T+2 and busy_o rises at T+2.
- DATA with start=1 on a running channel: immediate restart from bit0 with the new pattern; no done_tick for the aborted run.
- DATA with start=0, stop=0: shadow registers only; the running pattern is unaffected.
- stop=1 (overrides start): at T+2 the output goes to idle, busy_o goes to 0, and no done_tick is issued.
- Bit timing: bit i is held for P clocks. P = fast if freq_pattern[i]=1, else slow. Bits are sent LSB first.
- bit_tick_o pulses on the first cycle of each new bit, excluding bit0 of a fresh start.
- One-shot: after bit DATA_BIT-1 completes, done_tick_o pulses. In the same cycle the output returns to idle and busy_o drops. For the all-slow case this is cycle T+2+DATA_BIT*slow.
- Repeat: done_tick_o pulses at each wrap. bit0 of the next pass follows with no gap, and shadow values are reloaded at the wrap.
- Idle level: the idle bit is latched at commit and applies whenever the channel is IDLE.
- Channels are fully independent; simultaneous completions pulse simultaneously.
- A new rx byte during commit is accepted normally; parser and engines are decoupled.

Optional Feature:
- Macro PARSER_TIMEOUT_EN.
- Defined: while the parser is not IDLE, a counter tracks clocks since the last rx_done_tick_i. When it reaches TIMEOUT_CLK, the parser returns to IDLE, the partial packet is discarded, and cmd_err_o pulses once.
- Undefined: no counter; the parser waits indefinitely mid-packet.

Test Plan:
- Reset, then FREQ ch0 pattern 0x00000000 slow=20 fast=5, DATA 0x55555555 ctrl {0,0,0,0,1} -> ch0 alternates 1/0 every 20 clk; done_tick_o[0] at T+2+640; busy_o[0] low the same cycle; output 0.
- FREQ ch3 pattern 0xFFFF0000 slow=20 fast=5, DATA 0x55555555 repeat start -> bits 0-15 last 20 clk, bits 16-31 last 5 clk; done_tick_o[3] every 400 clk with no gap.
- All 16 channels one-shot, 0x55555555, default periods, sent back-to-back -> each done_tick spaced by the packet byte time; no cross-channel interference.
- Running ch1 repeat, then DATA ch1 ctrl stop=1 idle=1 -> serial_out_o[1]=1 and busy_o[1]=0 at T+2; no done_tick.
- Command byte 0x0C -> cmd_err_o pulse; a following valid packet is executed. DATA with chan=15 when OUTPUT_NUM=8 -> cmd_err_o pulse; no output change.
- With PARSER_TIMEOUT_EN: send 0x0B plus 2 bytes, then wait TIMEOUT_CLK -> cmd_err_o pulse, parser IDLE; the next full packet works.
